// File: rtl/pixel_framebuffer.sv
// Double-buffered pixel store between the UART byte stream and the HUB75 scan driver.
// Framed uploads fill the back bank; banks swap only on the driver's frame boundary.
module pixel_framebuffer #(
   parameter int         length   = 5,
   parameter int         bitdepth = 8,
   parameter int         scan_bit = 3,
   parameter logic [7:0] SYNC     = 8'hA5,
   localparam int        NPIX     = length * (1 << scan_bit),
   localparam int        AW       = $clog2(NPIX),
   localparam int        PW       = 3 * bitdepth
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] rd_addr,
   output logic [PW-1:0] data1,
   output logic [PW-1:0] data2,
   input  logic          frame_start,
   output logic          swapped,
   output logic          load_active
);

   localparam int PIXW = $clog2(2 * NPIX);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_PENDING
   } state_t;

   state_t              r_state;
   logic                r_fsel;
   logic                r_in_ready;
   logic                r_swapped;
   logic [PIXW-1:0]     r_pix;
   logic [1:0]          r_ch;
   logic [bitdepth-1:0] r_red;
   logic [bitdepth-1:0] r_grn;
   logic [PW-1:0]       r_data1;
   logic [PW-1:0]       r_data2;

   logic                w_accept;
   logic [bitdepth-1:0] w_chan;
   logic                w_last_pix;
   logic                w_we;
   logic                w_upper;
   logic [AW-1:0]       w_waddr;
   logic [PW-1:0]       w_wdata;
   logic                w_rd_ok;
   logic [AW-1:0]       w_raddr;
   logic [PW-1:0]       w_up_rd [2];
   logic [PW-1:0]       w_lo_rd [2];

   assign w_accept   = in_valid & r_in_ready;
   assign w_chan     = in_data[7 -: bitdepth];
   assign w_last_pix = (r_pix == PIXW'(2 * NPIX - 1));
   assign w_we       = w_accept && (r_state == S_LOAD) && (r_ch == 2'd2);
   assign w_upper    = (r_pix < PIXW'(NPIX));
   assign w_waddr    = w_upper ? AW'(r_pix) : AW'(r_pix - PIXW'(NPIX));
   assign w_wdata    = {r_red, r_grn, w_chan};

   // Out-of-range driver addresses read as black; clamp the index so the array is never overrun.
   assign w_rd_ok    = ({1'b0, rd_addr} < (AW + 1)'(NPIX));
   assign w_raddr    = w_rd_ok ? rd_addr : '0;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         logic [PW-1:0] r_up [NPIX];
         logic [PW-1:0] r_lo [NPIX];
         logic          w_is_back;

         assign w_is_back = (r_fsel != (gi == 1));

         always_ff @(posedge clk) begin
            if (w_we && w_is_back) begin
               if (w_upper) begin
                  r_up[w_waddr] <= w_wdata;
               end else begin
                  r_lo[w_waddr] <= w_wdata;
               end
            end
         end

         assign w_up_rd[gi] = r_up[w_raddr];
         assign w_lo_rd[gi] = r_lo[w_raddr];
      end
   endgenerate

   // r_fsel is sampled before the swap edge updates it, so the swap cycle still reads the old image.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data1 <= '0;
         r_data2 <= '0;
      end else begin
         r_data1 <= w_rd_ok ? w_up_rd[r_fsel] : '0;
         r_data2 <= w_rd_ok ? w_lo_rd[r_fsel] : '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_fsel     <= 1'b0;
         r_in_ready <= 1'b0;
         r_swapped  <= 1'b0;
         r_pix      <= '0;
         r_ch       <= 2'd0;
         r_red      <= '0;
         r_grn      <= '0;
      end else begin
         r_swapped <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_in_ready <= 1'b1;
               if (w_accept && (in_data == SYNC)) begin
                  r_state <= S_LOAD;
                  r_pix   <= '0;
                  r_ch    <= 2'd0;
               end
            end
            S_LOAD: begin
               r_in_ready <= 1'b1;
               if (w_accept) begin
                  case (r_ch)
                     2'd0: begin
                        r_red <= w_chan;
                        r_ch  <= 2'd1;
                     end
                     2'd1: begin
                        r_grn <= w_chan;
                        r_ch  <= 2'd2;
                     end
                     default: begin
                        r_ch <= 2'd0;
                        if (w_last_pix) begin
                           r_state    <= S_PENDING;
                           r_in_ready <= 1'b0;
                           r_pix      <= '0;
                        end else begin
                           r_pix <= r_pix + 1'b1;
                        end
                     end
                  endcase
               end
            end
            S_PENDING: begin
               r_in_ready <= 1'b0;
               if (frame_start) begin
                  r_fsel     <= ~r_fsel;
                  r_swapped  <= 1'b1;
                  r_state    <= S_IDLE;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign swapped     = r_swapped;
   assign load_active = (r_state == S_LOAD);
   assign data1       = r_data1;
   assign data2       = r_data2;

endmodule
